sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF stage (instruction fetch) and the
//  EX/MEM stages (data load/store). It arbitrates requests and holds a granted request
//  stable until the address handshake completes. An in-order owner FIFO tracks
//  outstanding transactions and routes each returning data_ok/rdata to the master that
//  issued it. Sits between the pipeline and the AXI bridge.
// PARAMETERS
//  OUTSTANDING  2  max accepted-but-unreturned transactions (>=1); depth of owner FIFO
//  DATA_FIRST   1  1: data master wins simultaneous requests; 0: inst master wins
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  resetn              in   1   asynchronous active-low reset
//  inst_sram_req       in   1   IF request
//  inst_sram_wr/size   in   1/2 IF write flag / size (0=B,1=H,2=W)
//  inst_sram_addr      in   32  IF address
//  inst_sram_wstrb     in   4   IF byte strobes
//  inst_sram_wdata     in   32  IF write data
//  inst_sram_addr_ok   out  1   IF request accepted this cycle
//  inst_sram_data_ok   out  1   IF response valid this cycle
//  inst_sram_rdata     out  32  IF read data (= mem_rdata)
//  data_sram_*         -    -   same nine signals, same widths/directions, for data master
//  inst_cancel         in   1   pulse: discard all outstanding/locked IF transactions
//  mem_req             out  1   request to memory port
//  mem_wr/size         out  1/2 forwarded write flag / size
//  mem_addr/wstrb/wdata out 32/4/32 forwarded address / strobes / write data
//  mem_addr_ok         in   1   memory accepted request
//  mem_data_ok         in   1   memory returns response (strictly in order)
//  mem_rdata           in   32  memory read data
// BEHAVIOUR
//  - Handshake: request accepted when mem_req & mem_addr_ok at rising edge; response when mem_data_ok.
//  - full = (count == OUTSTANDING), from registered count; no same-cycle pop bypass.
//  - Unlocked, not full: sel = priority winner among asserted reqs; mem_* = sel master's fields
//    (combinational); mem_req = winner exists. Full: mem_req=0, both addr_ok=0.
//  - Lock: mem_req & ~mem_addr_ok -> lock_vld<=1, latch owner and all request fields. While locked
//    mem_req=1, mem_* from latch, other master ignored. Cleared on handshake.
//  - x_sram_addr_ok = mem_addr_ok & mem_req & owner==x & ~(owner==INST & (lock_cancel|inst_cancel)).
//  - Accept: push {owner, cancel}; cancel=1 if INST and (lock_cancel or inst_cancel same cycle).
//  - inst_cancel: sets cancel on every valid INST FIFO entry; if locked to INST, sets lock_cancel
//    (transaction still completes on the port, result discarded). No effect on DATA entries.
//  - mem_data_ok pops head: data_sram_data_ok = head owner DATA; inst_sram_data_ok = head owner
//    INST & ~cancel. Both rdata outputs = mem_rdata. Latency: 0 cycles from mem_data_ok.
//  - Push and pop same cycle: both applied, count unchanged. Pointers wrap mod OUTSTANDING.
//  - mem_data_ok with count==0: ignored, no output, no state change (sim assertion fires).
//  - Reset (async, any time): count=0, pointers=0, lock_vld=0, lock_cancel=0, all cancel bits 0.
//    While resetn=0: mem_req, both addr_ok, both data_ok forced 0. Outstanding responses dropped.
// TESTING
//  1 Both req same cycle, addr_ok=1: data addr 0x0000_1000 issued cycle0, inst 0x1C00_0000 cycle1;
//    data_ok rdata 0x1234 -> data_sram_data_ok only, then 0xABCD -> inst_sram_data_ok only.
//  2 Inst req 0x1C00_0000, mem_addr_ok low 3 cycles, data req at cycle1 -> mem_addr held
//    0x1C00_0000 until accept at cycle3; data request issued cycle4.
//  3 OUTSTANDING=2, two accepted, no data_ok -> third req sees mem_req=0; one data_ok ->
//    third accepted next cycle, count returns to 2.
//  4 Inst accepted, inst_cancel pulse, then mem_data_ok -> inst_sram_data_ok stays 0, count 1->0;
//    cancel while locked -> request completes, inst addr_ok stays 0.
//  5 resetn low mid-op with 2 outstanding -> mem_req/addr_ok/data_ok 0 immediately, count=0,
//    lock clear after release.
//  6 mem_data_ok with empty FIFO -> no data_ok on either master, count stays 0.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// One SRAM-like request/response port: request fields, address handshake and
// in-order read-data return. Used for both pipeline masters and the memory side.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Requester side: drives the request, receives handshake and response.
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Responder side: receives the request, drives handshake and response.
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch master and the
// data master. A request that is presented but not accepted is locked until the
// memory takes it; an in-order owner FIFO routes each response back to its
// issuer, dropping responses of fetches that were cancelled in flight.
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_cancel,
  sram_req_arbiter_if.slave     inst_sram,
  sram_req_arbiter_if.slave     data_sram,
  sram_req_arbiter_if.master    mem
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic { OWN_INST = 1'b0, OWN_DATA = 1'b1 } owner_e;
  typedef enum logic { ST_OPEN = 1'b0, ST_LOCKED = 1'b1 } lock_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_fields_t;

  // Lock state
  lock_state_e state_q, state_d;
  owner_e      lock_owner_q, lock_owner_d;
  req_fields_t lock_fields_q, lock_fields_d;
  logic        lock_cancel_q, lock_cancel_d;

  // Owner FIFO state
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  owner_e           fifo_owner_q  [OUTSTANDING];
  logic             fifo_cancel_q [OUTSTANDING];

  // Combinational arbitration results
  req_fields_t inst_fields, data_fields, win_fields, cur_fields;
  owner_e      win_owner, cur_owner, head_owner;
  logic        win_vld, cur_req, cur_cancel, full, accept, pop, head_cancel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inst_fields = {inst_sram.wr, inst_sram.size, inst_sram.addr, inst_sram.wstrb, inst_sram.wdata};
  assign data_fields = {data_sram.wr, data_sram.size, data_sram.addr, data_sram.wstrb, data_sram.wdata};

  // Fixed-priority winner among the live requests.
  always_comb begin
    win_vld = inst_sram.req | data_sram.req;
    if (DATA_FIRST) begin
      win_owner = data_sram.req ? OWN_DATA : OWN_INST;
    end else begin
      win_owner = inst_sram.req ? OWN_INST : OWN_DATA;
    end
    win_fields = (win_owner == OWN_DATA) ? data_fields : inst_fields;
  end

  // The full check uses the registered count only; a pop in the same cycle does
  // not free a slot until the next cycle.
  assign full = (count_q == CNT_W'(OUTSTANDING));

  // Select what is presented on the memory port: locked request wins, else the
  // live winner when a FIFO slot is free. Nothing is presented during reset.
  always_comb begin
    cur_req    = 1'b0;
    cur_owner  = win_owner;
    cur_fields = win_fields;
    if (state_q == ST_LOCKED) begin
      cur_req    = 1'b1;
      cur_owner  = lock_owner_q;
      cur_fields = lock_fields_q;
    end else if (!full) begin
      cur_req    = win_vld;
    end
    if (!resetn) begin
      cur_req = 1'b0;
    end
  end

  assign cur_cancel = (cur_owner == OWN_INST) & (lock_cancel_q | inst_cancel);
  assign accept     = cur_req & mem.addr_ok;

  assign mem.req   = cur_req;
  assign mem.wr    = cur_fields.wr;
  assign mem.size  = cur_fields.size;
  assign mem.addr  = cur_fields.addr;
  assign mem.wstrb = cur_fields.wstrb;
  assign mem.wdata = cur_fields.wdata;

  // A cancelled fetch still completes its handshake on the memory side, but the
  // fetch master is never told it was accepted.
  assign inst_sram.addr_ok = accept & (cur_owner == OWN_INST) & ~cur_cancel;
  assign data_sram.addr_ok = accept & (cur_owner == OWN_DATA);

  // Responses are routed from the FIFO head; a stray response with nothing
  // outstanding is ignored.
  assign head_owner  = fifo_owner_q[rd_ptr_q];
  assign head_cancel = fifo_cancel_q[rd_ptr_q];
  assign pop         = mem.data_ok & (count_q != '0) & resetn;

  assign data_sram.data_ok = pop & (head_owner == OWN_DATA);
  assign inst_sram.data_ok = pop & (head_owner == OWN_INST) & ~head_cancel;
  assign data_sram.rdata   = mem.rdata;
  assign inst_sram.rdata   = mem.rdata;

  // Lock next-state: capture a presented-but-refused request, release on handshake.
  always_comb begin
    state_d       = state_q;
    lock_owner_d  = lock_owner_q;
    lock_fields_d = lock_fields_q;
    lock_cancel_d = lock_cancel_q;
    case (state_q)
      ST_OPEN: begin
        if (cur_req && !mem.addr_ok) begin
          state_d       = ST_LOCKED;
          lock_owner_d  = cur_owner;
          lock_fields_d = cur_fields;
          // A cancel arriving in the very cycle the fetch gets locked also
          // applies to it, so the fetch master never sees a stale addr_ok.
          lock_cancel_d = cur_cancel;
        end
      end
      ST_LOCKED: begin
        if (inst_cancel && (lock_owner_q == OWN_INST)) begin
          lock_cancel_d = 1'b1;
        end
        if (mem.addr_ok) begin
          state_d       = ST_OPEN;
          lock_cancel_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_OPEN;
        lock_cancel_d = 1'b0;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_OPEN;
      lock_owner_q  <= OWN_INST;
      lock_fields_q <= '0;
      lock_cancel_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_owner_q  <= lock_owner_d;
      lock_fields_q <= lock_fields_d;
      lock_cancel_q <= lock_cancel_d;
    end
  end

  // FIFO occupancy and pointer next-state; push and pop together leave count unchanged.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // FIFO occupancy and pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // One owner/cancel slot per outstanding transaction.
  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_entry
    logic entry_valid;

    // Slot is live when its distance from the read pointer is below the count.
    assign entry_valid = (((gi >= int'(rd_ptr_q)) ? (gi - int'(rd_ptr_q))
                                                  : (gi + OUTSTANDING - int'(rd_ptr_q)))
                          < int'(count_q));

    // Write on push; otherwise mark live fetch entries cancelled on inst_cancel.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        fifo_owner_q[gi]  <= OWN_INST;
        fifo_cancel_q[gi] <= 1'b0;
      end else if (accept && (wr_ptr_q == PTR_W'(gi))) begin
        fifo_owner_q[gi]  <= cur_owner;
        fifo_cancel_q[gi] <= cur_cancel;
      end else if (inst_cancel && entry_valid && (fifo_owner_q[gi] == OWN_INST)) begin
        fifo_cancel_q[gi] <= 1'b1;
      end
    end
  end

`ifdef SRAM_REQ_ARBITER_ASSERT_EMPTY_POP
  // Flags a memory response arriving with nothing outstanding.
  always @(posedge clk) begin
    if (resetn) begin
      assert (!(mem.data_ok && (count_q == '0)))
        else $error("sram_req_arbiter: mem_data_ok with empty owner FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: stimulus drives both masters and the
// memory side; expected responses go into a queue that a separate monitor
// drains whenever either master sees data_ok.
module tb_sram_req_arbiter;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic clk;
  logic resetn;
  logic inst_cancel;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if mem_if ();

  sram_req_arbiter #(.OUTSTANDING(2), .DATA_FIRST(1'b1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_cancel (inst_cancel),
    .inst_sram   (inst_if),
    .data_sram   (data_if),
    .mem         (mem_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string nm, input int exp);
    chk32(nm, 32'(dut.count_q), 32'(exp));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    inst_if.req     = 1'b0;
    data_if.req     = 1'b0;
    mem_if.addr_ok  = 1'b0;
    mem_if.data_ok  = 1'b0;
    inst_cancel     = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] a);
    inst_if.req   = 1'b1;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.addr  = a;
    inst_if.wstrb = 4'h0;
    inst_if.wdata = 32'h0;
  endtask

  task automatic set_data(input logic w, input logic [31:0] a, input logic [31:0] wd);
    data_if.req   = 1'b1;
    data_if.wr    = w;
    data_if.size  = 2'd2;
    data_if.addr  = a;
    data_if.wstrb = w ? 4'hF : 4'h0;
    data_if.wdata = wd;
  endtask

  // Queue an expected response and present it on the memory side this cycle.
  task automatic respond(input logic own, input logic [31:0] rd);
    exp_q.push_back({own, rd});
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = rd;
  endtask

  // Monitor: every data_ok seen by a master must match the queue head.
  initial begin
    logic [32:0] e;
    logic [32:0] a;
    forever begin
      @(negedge clk);
      #3;
      if (inst_if.data_ok || data_if.data_ok) begin
        n_checks++;
        a = {data_if.data_ok, data_if.data_ok ? data_if.rdata : inst_if.rdata};
        if (inst_if.data_ok && data_if.data_ok) begin
          n_fail++;
          $display("FAIL rsp_both_masters actual=both_data_ok required=one @%0t", $time);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected actual_owner=%0d rdata=0x%08h required=none @%0t",
                   a[32], a[31:0], $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL rsp_route actual_owner=%0d rdata=0x%08h required_owner=%0d rdata=0x%08h @%0t",
                     a[32], a[31:0], e[32], e[31:0], $time);
          end else begin
            $display("rsp owner=%0d rdata=0x%08h ok @%0t", a[32], a[31:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn       = 1'b0;
    mem_if.rdata = 32'h0;
    set_inst(32'h0);
    set_data(1'b0, 32'h0, 32'h0);
    idle();

    // Reset: port quiet even with request, addr_ok and data_ok present.
    nxt(); set_data(1'b0, 32'h0000_0100, 32'h0); mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; #1;
    chk1("rst_mem_req", mem_if.req, 1'b0);
    chk1("rst_data_addr_ok", data_if.addr_ok, 1'b0);
    chk1("rst_data_data_ok", data_if.data_ok, 1'b0);
    chk_cnt("rst_count", 0);
    nxt(); idle(); resetn = 1'b1;

    // T1: simultaneous requests, data wins then fetch; in-order routing.
    nxt(); set_data(1'b1, 32'h0000_1000, 32'hDEAD_BEEF); set_inst(32'h1C00_0000); mem_if.addr_ok = 1'b1; #1;
    chk1("t1_c0_mem_req", mem_if.req, 1'b1);
    chk32("t1_c0_mem_addr", mem_if.addr, 32'h0000_1000);
    chk1("t1_c0_mem_wr", mem_if.wr, 1'b1);
    chk32("t1_c0_mem_wdata", mem_if.wdata, 32'hDEAD_BEEF);
    chk1("t1_c0_data_addr_ok", data_if.addr_ok, 1'b1);
    chk1("t1_c0_inst_addr_ok", inst_if.addr_ok, 1'b0);
    nxt(); data_if.req = 1'b0; #1;
    chk32("t1_c1_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk1("t1_c1_mem_wr", mem_if.wr, 1'b0);
    chk1("t1_c1_inst_addr_ok", inst_if.addr_ok, 1'b1);
    chk1("t1_c1_data_addr_ok", data_if.addr_ok, 1'b0);
    nxt(); idle(); respond(OWN_D, 32'h0000_1234); #1;
    chk_cnt("t1_count2", 2);
    nxt(); respond(OWN_I, 32'h0000_ABCD); #1;
    chk_cnt("t1_count1", 1);
    nxt(); idle(); #1;
    chk_cnt("t1_count0", 0);

    // T2: fetch held for three refused cycles; data waits behind the lock.
    nxt(); set_inst(32'h1C00_0000); #1;
    chk1("t2_c0_mem_req", mem_if.req, 1'b1);
    chk32("t2_c0_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk1("t2_c0_inst_addr_ok", inst_if.addr_ok, 1'b0);
    nxt(); set_data(1'b0, 32'h0000_2000, 32'h0); inst_if.addr = 32'h1C00_0040; #1;
    chk32("t2_c1_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk1("t2_c1_data_addr_ok", data_if.addr_ok, 1'b0);
    nxt(); #1;
    chk32("t2_c2_mem_addr", mem_if.addr, 32'h1C00_0000);
    nxt(); mem_if.addr_ok = 1'b1; #1;
    chk32("t2_c3_mem_addr", mem_if.addr, 32'h1C00_0000);
    chk1("t2_c3_inst_addr_ok", inst_if.addr_ok, 1'b1);
    chk1("t2_c3_data_addr_ok", data_if.addr_ok, 1'b0);
    nxt(); inst_if.req = 1'b0; #1;
    chk32("t2_c4_mem_addr", mem_if.addr, 32'h0000_2000);
    chk1("t2_c4_data_addr_ok", data_if.addr_ok, 1'b1);
    nxt(); idle(); respond(OWN_I, 32'h0000_0011);
    nxt(); respond(OWN_D, 32'h0000_0022);
    nxt(); idle(); #1;
    chk_cnt("t2_count0", 0);

    // T3: full FIFO blocks new requests; a pop frees a slot one cycle later.
    nxt(); set_data(1'b0, 32'h0000_3000, 32'h0); mem_if.addr_ok = 1'b1; #1;
    chk1("t3_c0_data_addr_ok", data_if.addr_ok, 1'b1);
    nxt(); data_if.addr = 32'h0000_3004; #1;
    chk1("t3_c1_data_addr_ok", data_if.addr_ok, 1'b1);
    nxt(); data_if.addr = 32'h0000_3008; set_inst(32'h1C00_0010); #1;
    chk1("t3_full_mem_req", mem_if.req, 1'b0);
    chk1("t3_full_data_addr_ok", data_if.addr_ok, 1'b0);
    chk1("t3_full_inst_addr_ok", inst_if.addr_ok, 1'b0);
    chk_cnt("t3_full_count", 2);
    nxt(); respond(OWN_D, 32'h0000_0033); #1;
    chk1("t3_popcyc_mem_req", mem_if.req, 1'b0);
    chk1("t3_popcyc_data_addr_ok", data_if.addr_ok, 1'b0);
    nxt(); mem_if.data_ok = 1'b0; #1;
    chk1("t3_after_mem_req", mem_if.req, 1'b1);
    chk32("t3_after_mem_addr", mem_if.addr, 32'h0000_3008);
    chk1("t3_after_data_addr_ok", data_if.addr_ok, 1'b1);
    chk1("t3_after_inst_addr_ok", inst_if.addr_ok, 1'b0);
    chk_cnt("t3_after_count", 1);
    nxt(); idle(); #1;
    chk_cnt("t3_refill_count", 2);
    nxt(); respond(OWN_D, 32'h0000_0034);
    nxt(); respond(OWN_D, 32'h0000_0035);
    nxt(); idle(); #1;
    chk_cnt("t3_count0", 0);

    // T4a: cancel drops an outstanding fetch but not the data ahead of it.
    nxt(); set_data(1'b0, 32'h0000_4000, 32'h0); set_inst(32'h1C00_0100); mem_if.addr_ok = 1'b1; #1;
    chk1("t4_c0_data_addr_ok", data_if.addr_ok, 1'b1);
    nxt(); data_if.req = 1'b0; #1;
    chk1("t4_c1_inst_addr_ok", inst_if.addr_ok, 1'b1);
    nxt(); idle(); inst_cancel = 1'b1; #1;
    chk_cnt("t4_count2", 2);
    nxt(); inst_cancel = 1'b0; respond(OWN_D, 32'h0000_0044);
    nxt(); mem_if.rdata = 32'h0000_0045; #1;
    chk1("t4_cancel_inst_data_ok", inst_if.data_ok, 1'b0);
    chk1("t4_cancel_data_data_ok", data_if.data_ok, 1'b0);
    chk_cnt("t4_popcyc_count", 1);
    nxt(); idle(); #1;
    chk_cnt("t4_count0", 0);

    // T4b: cancel while locked: port handshake completes, fetch never acknowledged.
    nxt(); set_inst(32'h1C00_0200); #1;
    chk1("t4b_c0_inst_addr_ok", inst_if.addr_ok, 1'b0);
    nxt(); inst_if.req = 1'b0; inst_cancel = 1'b1; #1;
    chk1("t4b_c1_mem_req", mem_if.req, 1'b1);
    chk32("t4b_c1_mem_addr", mem_if.addr, 32'h1C00_0200);
    nxt(); inst_cancel = 1'b0; mem_if.addr_ok = 1'b1; #1;
    chk1("t4b_c2_mem_req", mem_if.req, 1'b1);
    chk32("t4b_c2_mem_addr", mem_if.addr, 32'h1C00_0200);
    chk1("t4b_c2_inst_addr_ok", inst_if.addr_ok, 1'b0);
    nxt(); idle(); #1;
    chk1("t4b_c3_mem_req", mem_if.req, 1'b0);
    chk_cnt("t4b_count1", 1);
    nxt(); mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0046; #1;
    chk1("t4b_inst_data_ok", inst_if.data_ok, 1'b0);
    nxt(); idle(); #1;
    chk_cnt("t4b_count0", 0);

    // T5a: async reset with two outstanding.
    nxt(); set_data(1'b0, 32'h0000_5000, 32'h0); mem_if.addr_ok = 1'b1;
    nxt(); data_if.addr = 32'h0000_5004; #1;
    chk_cnt("t5_count1", 1);
    nxt(); #1;
    chk_cnt("t5_count2", 2);
    #1; resetn = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0055; #1;
    chk1("t5_rst_mem_req", mem_if.req, 1'b0);
    chk1("t5_rst_data_addr_ok", data_if.addr_ok, 1'b0);
    chk1("t5_rst_data_data_ok", data_if.data_ok, 1'b0);
    chk1("t5_rst_inst_data_ok", inst_if.data_ok, 1'b0);
    chk_cnt("t5_rst_count", 0);
    nxt(); #1;
    chk1("t5_rst2_mem_req", mem_if.req, 1'b0);
    nxt(); idle(); resetn = 1'b1;

    // T5b: reset while locked to a fetch clears the lock.
    nxt(); set_inst(32'h1C00_0300); #1;
    chk32("t5b_lock_mem_addr", mem_if.addr, 32'h1C00_0300);
    nxt(); #2; resetn = 1'b0; #1;
    chk1("t5b_rst_mem_req", mem_if.req, 1'b0);
    nxt(); resetn = 1'b1; inst_if.req = 1'b0; set_data(1'b0, 32'h0000_5100, 32'h0); mem_if.addr_ok = 1'b1; #1;
    chk32("t5b_post_mem_addr", mem_if.addr, 32'h0000_5100);
    chk1("t5b_post_data_addr_ok", data_if.addr_ok, 1'b1);
    chk1("t5b_post_inst_addr_ok", inst_if.addr_ok, 1'b0);
    chk_cnt("t5b_post_count", 0);
    nxt(); idle(); respond(OWN_D, 32'h0000_0057); #1;
    chk_cnt("t5b_count1", 1);
    nxt(); idle(); #1;
    chk_cnt("t5b_count0", 0);

    // T6: response with nothing outstanding is ignored.
    nxt(); mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_0066; #1;
    chk1("t6_inst_data_ok", inst_if.data_ok, 1'b0);
    chk1("t6_data_data_ok", data_if.data_ok, 1'b0);
    nxt(); idle(); #1;
    chk_cnt("t6_count0", 0);
    nxt(); set_data(1'b0, 32'h0000_6000, 32'h0); mem_if.addr_ok = 1'b1; #1;
    chk1("t6_data_addr_ok", data_if.addr_ok, 1'b1);
    nxt(); idle(); respond(OWN_D, 32'h0000_0067);
    nxt(); idle(); #1;
    chk_cnt("t6_final_count", 0);

    nxt();
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
